// File: rtl/udp_02467_pkg.sv
// Shared definitions for the UDP_02467 sweeper: state encoding, golden maps
// and the golden E/F function (E = C' + AB, F = E & D).
package udp_02467_pkg;

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned ERR_W   = 5;
    localparam int unsigned CNT_W   = 4;

    localparam logic [NUM_VEC-1:0] E_GOLD = 16'hF333;
    localparam logic [NUM_VEC-1:0] F_GOLD = 16'hA222;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Returns {e, f} for one input combination.
    function automatic logic [1:0] exp_ef(input logic a, input logic b,
                                          input logic c, input logic d);
        logic e;
        e = ~c | (a & b);
        return {e, e & d};
    endfunction

endpackage

// File: rtl/udp_02467_golden.sv
// Combinational golden reference for UDP_02467.
// Ports: a_i..d_i  circuit inputs; exp_e_c/exp_f_c  expected E/F (combinational).
module udp_02467_golden
    import udp_02467_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    input  logic d_i,
    output logic exp_e_c,
    output logic exp_f_c
);

    logic [1:0] ef;

    assign ef      = exp_ef(a_i, b_i, c_i, d_i);
    assign exp_e_c = ef[1];
    assign exp_f_c = ef[0];

endmodule

// File: rtl/udp_02467_sweeper.sv
// Stimulus-and-check sweeper for the UDP_02467 circuit: drives all 16
// {A,B,C,D} vectors, samples E/F after SETTLE_CYCLES, compares with golden.
// Ports: clock/reset_b; start (pulse), abort (level); e_in/f_in circuit
// responses; a/b/c/d_out stimulus; busy/done/pass status; err_count,
// e_map/f_map, first_fail_idx/first_fail_valid results. All outputs registered.
module udp_02467_sweeper
    import udp_02467_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
)
(
    input  logic               clock,
    input  logic               reset_b,
    input  logic               start,
    input  logic               abort,
    input  logic               e_in,
    input  logic               f_in,
    output logic               a_out,
    output logic               b_out,
    output logic               c_out,
    output logic               d_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [NUM_VEC-1:0] e_map,
    output logic [NUM_VEC-1:0] f_map,
    output logic [IDX_W-1:0]   first_fail_idx,
    output logic               first_fail_valid
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VEC - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic [IDX_W-1:0]     stim_q, stim_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [NUM_VEC-1:0]   e_map_q, e_map_d;
    logic [NUM_VEC-1:0]   f_map_q, f_map_d;
    logic [IDX_W-1:0]     ffi_q, ffi_d;
    logic                 ffv_q, ffv_d;

    logic                 exp_e_c, exp_f_c;
    logic                 mismatch_c;

    // Golden response for the vector currently on the stimulus outputs.
    udp_02467_golden u_golden (
        .a_i     (idx_q[3]),
        .b_i     (idx_q[2]),
        .c_i     (idx_q[1]),
        .d_i     (idx_q[0]),
        .exp_e_c (exp_e_c),
        .exp_f_c (exp_f_c)
    );

    // Case-inequality so an X/Z response is reported as a mismatch.
    assign mismatch_c = (e_in !== exp_e_c) || (f_in !== exp_f_c);

    // Next-state, counters, results and registered-output values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        pass_d  = pass_q;
        err_d   = err_q;
        e_map_d = e_map_q;
        f_map_d = f_map_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    e_map_d = '0;
                    f_map_d = '0;
                    err_d   = '0;
                    ffi_d   = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    wait_d  = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (wait_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    wait_d = CNT_W'(wait_q + CNT_W'(1));
                end
            end
            ST_SAMPLE: begin
                e_map_d[idx_q] = e_in;
                f_map_d[idx_q] = f_in;
                if (mismatch_c) begin
                    err_d = ERR_W'(err_q + ERR_W'(1));
                    if (!ffv_q) begin
                        ffi_d = idx_q;
                        ffv_d = 1'b1;
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    idx_d   = IDX_W'(idx_q + IDX_W'(1));
                    wait_d  = '0;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort outranks start and every other transition; results are kept.
        if (abort) begin
            state_d = ST_IDLE;
            pass_d  = 1'b0;
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        stim_d = busy_d ? idx_d : '0;
    end

    // State and result registers.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            e_map_q <= '0;
            f_map_q <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            e_map_q <= e_map_d;
            f_map_q <= f_map_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
        end
    end

    assign a_out            = stim_q[3];
    assign b_out            = stim_q[2];
    assign c_out            = stim_q[1];
    assign d_out            = stim_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign e_map            = e_map_q;
    assign f_map            = f_map_q;
    assign first_fail_idx   = ffi_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_udp_02467_sweeper.sv
// Directed bench for udp_02467_sweeper: a default instance (SETTLE_CYCLES=2)
// driving a faultable model of the circuit, and a SETTLE_CYCLES=1 instance
// driving a fault-free circuit model.
module tb_udp_02467_sweeper;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_b, start, abort, start2;
    int   fault;
    int   checks = 0;
    int   errors = 0;

    // Instance 1 (SETTLE_CYCLES = 2)
    logic        a_out, b_out, c_out, d_out, e_in, f_in;
    logic        busy, done, pass, ffv;
    logic [4:0]  err_count;
    logic [15:0] e_map, f_map;
    logic [3:0]  ffi, stim;

    // Instance 2 (SETTLE_CYCLES = 1)
    logic        a2, b2, c2, d2, e2, f2;
    logic        busy2, done2, pass2, ffv2;
    logic [4:0]  err2;
    logic [15:0] e_map2, f_map2;
    logic [3:0]  ffi2;

    assign stim = {a_out, b_out, c_out, d_out};

    // Circuit under test, with optional planted faults.
    always_comb begin
        e_in = ~c_out | (a_out & b_out);
        f_in = (~c_out | (a_out & b_out)) & d_out;
        if (fault == 1) e_in = 1'b0;
        if (fault == 2 && stim == 4'd9) f_in = ~f_in;
    end

    assign e2 = ~c2 | (a2 & b2);
    assign f2 = (~c2 | (a2 & b2)) & d2;

    udp_02467_sweeper #(.SETTLE_CYCLES(2)) dut (
        .clock(clock), .reset_b(reset_b), .start(start), .abort(abort),
        .e_in(e_in), .f_in(f_in),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .e_map(e_map), .f_map(f_map),
        .first_fail_idx(ffi), .first_fail_valid(ffv)
    );

    udp_02467_sweeper #(.SETTLE_CYCLES(1)) dut2 (
        .clock(clock), .reset_b(reset_b), .start(start2), .abort(1'b0),
        .e_in(e2), .f_in(f2),
        .a_out(a2), .b_out(b2), .c_out(c2), .d_out(d2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .e_map(e_map2), .f_map(f_map2),
        .first_fail_idx(ffi2), .first_fail_valid(ffv2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulses start on instance 1 and returns edges until done (0 on timeout).
    task automatic sweep1(output int n);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (done) break;
        end
        if (!done) n = 0;
    endtask

    initial begin
        int n;
        int found;
        reset_b = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        start2  = 1'b0;
        fault   = 0;
        #12;
        check("rst_stim",  32'(stim), 32'h0);
        check("rst_flags", 32'({busy, done, pass, ffv}), 32'h0);
        check("rst_err",   32'(err_count), 32'h0);
        check("rst_maps",  {e_map, f_map}, 32'h0);
        check("rst_ffi",   32'(ffi), 32'h0);
        reset_b = 1'b1;
        tick();
        tick();
        check("idle_no_activity", 32'({busy, done}), 32'h0);

        // Correct circuit
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'({busy, done}), 32'h2);
        check("stim_vec0", 32'(stim), 32'h0);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) break;
            n++;
        end
        check("lat48", 32'(n), 32'd48);
        check("good_e_map", 32'(e_map), 32'hF333);
        check("good_f_map", 32'(f_map), 32'hA222);
        check("good_err",   32'(err_count), 32'd0);
        check("good_pass",  32'({pass, ffv}), 32'h2);
        check("done_stim0", 32'({busy, stim}), 32'h0);

        // E stuck at 0
        fault = 1;
        sweep1(n);
        check("e0_lat",   32'(n), 32'd48);
        check("e0_err",   32'(err_count), 32'd10);
        check("e0_ffi",   32'({ffv, ffi}), 32'h10);
        check("e0_pass",  32'(pass), 32'd0);
        check("e0_e_map", 32'(e_map), 32'h0000);
        check("e0_f_map", 32'(f_map), 32'hA222);

        // F inverted at vector 9
        fault = 2;
        sweep1(n);
        check("f9_err",   32'(err_count), 32'd1);
        check("f9_ffi",   32'({ffv, ffi}), 32'h19);
        check("f9_f_map", 32'(f_map), 32'hA022);
        check("f9_e_map", 32'(e_map), 32'hF333);
        check("f9_pass",  32'(pass), 32'd0);

        // Abort (with start) in the cycle idx becomes 5
        fault = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (stim == 4'd5) begin
                found = 1;
                break;
            end
        end
        check("abort_reach_idx5", 32'(found), 32'd1);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_flags", 32'({busy, done, pass}), 32'h0);
        check("abort_stim",  32'(stim), 32'h0);
        check("abort_e_map", 32'(e_map), 32'h0013);
        check("abort_f_map", 32'(f_map), 32'h0002);
        repeat (5) tick();
        check("abort_stays_idle", 32'({busy, done}), 32'h0);
        sweep1(n);
        check("rerun_lat",  32'(n), 32'd48);
        check("rerun_pass", 32'(pass), 32'd1);
        check("rerun_maps", {e_map, f_map}, 32'hF333A222);

        // Asynchronous reset mid-SETTLE
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("pre_rst_e_map", 32'(e_map), 32'h0003);
        #2;
        reset_b = 1'b0;
        #1;
        check("arst_stim",  32'(stim), 32'h0);
        check("arst_flags", 32'({busy, done, pass, ffv}), 32'h0);
        check("arst_maps",  {e_map, f_map}, 32'h0);
        check("arst_err",   32'(err_count), 32'h0);
        #1;
        reset_b = 1'b1;
        repeat (10) tick();
        check("post_rst_idle", 32'({busy, done, stim}), 32'h0);

        // SETTLE_CYCLES = 1: start while busy ignored, restart from DONE
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 1;
        for (int i = 0; i < 200; i++) begin
            start2 = (n == 10);
            tick();
            start2 = 1'b0;
            if (done2) break;
            n++;
        end
        check("s1_lat32",  32'(n), 32'd32);
        check("s1_maps",   {e_map2, f_map2}, 32'hF333A222);
        check("s1_pass",   32'({pass2, ffv2, err2}), 32'h40);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("s1_restart_clear", {e_map2, f_map2}, 32'h0);
        check("s1_restart_flags", 32'({busy2, done2, pass2}), 32'h4);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done2) break;
            n++;
        end
        check("s1_second_lat", 32'(n), 32'd32);
        check("s1_second_pass", 32'(pass2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
